ram_fifo_ctrl: RTL and testbench



---
 rtl/ram_fifo_ctrl.sv | 129 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO controller using an external dual-port RAM as storage, plus a 2-entry output queue.
// Latency: a word accepted at edge E0 is read at E1, queued at E2, and m_valid is high after E2.
// Backpressure: s_ready drops only when the RAM holds DEPTH words; the read side stalls on m_ready through the output queue.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BWEN_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [ADDR_WIDTH+1:0]   count,
    output logic                    ram_cen,
    output logic                    ram_wen_a,
    output logic [ADDR_WIDTH-1:0]   ram_addr_a,
    output logic [DATA_WIDTH-1:0]   ram_din_a,
    output logic                    ram_wen_b,
    output logic [BWEN_WIDTH-1:0]   ram_bwen_b,
    output logic [ADDR_WIDTH-1:0]   ram_addr_b,
    output logic [DATA_WIDTH-1:0]   ram_din_b,
    input  logic [DATA_WIDTH-1:0]   ram_dout_b
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    // RAM bookkeeping
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    // High in the cycle ram_dout_b carries the word read at the previous edge
    logic                  rd_pend;

    // Output queue: q_head is always the oldest entry
    logic [1:0]            q_cnt;
    logic [DATA_WIDTH-1:0] q_head;
    logic [DATA_WIDTH-1:0] q_tail;

    logic                  wr_fire;
    logic                  rd_issue;
    logic                  m_fire;

    logic [1:0]            q_keep;
    logic [1:0]            q_cnt_nxt;
    logic [DATA_WIDTH-1:0] q_head_nxt;
    logic [DATA_WIDTH-1:0] q_tail_nxt;

    // Write acceptance depends only on RAM occupancy, never on the consumer
    assign s_ready = (ram_cnt < FULL_CNT) && !flush;
    assign wr_fire = s_valid && s_ready;

    assign m_valid = (q_cnt != 2'd0);
    assign m_data  = q_head;
    assign m_fire  = m_valid && m_ready;

    // Issue a read only if the word will have a queue slot when it lands
    assign rd_issue = (ram_cnt != '0)
                   && (({1'b0, q_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, m_fire}))
                   && !flush;

    assign ram_cen    = wr_fire | rd_issue;
    assign ram_wen_a  = wr_fire;
    assign ram_addr_a = wr_ptr;
    assign ram_din_a  = s_data;
    assign ram_wen_b  = 1'b0;
    assign ram_bwen_b = '1;
    assign ram_addr_b = rd_ptr;
    assign ram_din_b  = '0;

    assign count = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(rd_pend) + (ADDR_WIDTH+2)'(q_cnt);

    // Queue next state: pop shifts the tail forward, then a landing RAM word fills the first free slot
    always_comb begin
        q_head_nxt = q_head;
        q_tail_nxt = q_tail;
        q_keep     = q_cnt - {1'b0, m_fire};
        if (m_fire) begin
            q_head_nxt = q_tail;
        end
        if (rd_pend) begin
            if (q_keep == 2'd0) begin
                q_head_nxt = ram_dout_b;
            end else begin
                q_tail_nxt = ram_dout_b;
            end
        end
        q_cnt_nxt = q_keep + {1'b0, rd_pend};
    end

    // Pointer, counter and queue registers; flush leaves the same state as reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            q_cnt   <= 2'd0;
            q_head  <= '0;
            q_tail  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            q_cnt   <= 2'd0;
            q_head  <= '0;
            q_tail  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(wr_fire) - (ADDR_WIDTH+1)'(rd_issue);
            rd_pend <= rd_issue;
            q_cnt   <= q_cnt_nxt;
            q_head  <= q_head_nxt;
            q_tail  <= q_tail_nxt;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a word-queue reference model.
// Every accepted word must come out in order; count must equal words held.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_ram_fifo_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CAP   = DEPTH + 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          ram_cen;
    logic          ram_wen_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_wen_b;
    logic [DW/8-1:0] ram_bwen_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_din_b;
    logic [DW-1:0] ram_dout_b;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] mem [0:DEPTH-1];

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .ram_cen(ram_cen), .ram_wen_a(ram_wen_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_wen_b(ram_wen_b), .ram_bwen_b(ram_bwen_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
        .ram_dout_b(ram_dout_b)
    );

    initial forever #5 clock = ~clock;

    // Dual-port RAM with registered port-B read
    always @(posedge clock) begin
        if (ram_cen) begin
            if (ram_wen_a) mem[ram_addr_a] <= ram_din_a;
            if (ram_wen_b) mem[ram_addr_b] <= ram_din_b;
            ram_dout_b <= mem[ram_addr_b];
        end
    end

    // Called at the falling edge: apply this cycle's handshakes to the model, then move past the next rising edge
    task automatic advance();
        if (flush) begin
            model_q.delete();
        end else begin
            if (m_valid && m_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (s_valid && s_ready) model_q.push_back(s_data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0d want=1", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0d want=0", m_valid); end
        total++; if (count !== 0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (ram_cen !== 1'b0) begin bad++; $display("FAIL reset_ram_cen got=%0d want=0", ram_cen); end
        total++; if (ram_wen_a !== 1'b0) begin bad++; $display("FAIL reset_ram_wen_a got=%0d want=0", ram_wen_a); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%0h want=0", m_data); end
        total++; if (ram_wen_b !== 1'b0 || ram_bwen_b !== 4'hF || ram_din_b !== 32'h0) begin
            bad++; $display("FAIL port_b_ties got wen=%0d bwen=%0h din=%0h want 0/f/0", ram_wen_b, ram_bwen_b, ram_din_b);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        model_q.delete();
    endtask

    task automatic test_single_word();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 32'hA5A5_0001;
        @(negedge clock);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_s_ready got=%0d want=1", s_ready); end
        total++; if (ram_addr_a !== 4'd0 || ram_wen_a !== 1'b1) begin
            bad++; $display("FAIL single_write_port got addr=%0d wen=%0d want 0/1", ram_addr_a, ram_wen_a);
        end
        advance();
        s_valid = 1'b0; s_data = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid cyc=%0d got=%0d want=0", i, m_valid); end
            total++; if (count !== 1) begin bad++; $display("FAIL single_count_inflight cyc=%0d got=%0d want=1", i, count); end
            advance();
        end
        @(negedge clock);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0d want=1", m_valid); end
        total++; if (m_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_data got=%0h want=a5a50001", m_data); end
        total++; if (count !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
        advance();
        @(negedge clock);
        total++; if (m_valid !== 1'b0 || count !== 0) begin
            bad++; $display("FAIL single_drained got valid=%0d count=%0d want 0/0", m_valid, count);
        end
        advance();
    endtask

    task automatic test_fill();
        int next = 0;
        int rx = 0;
        logic fire;
        m_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            s_valid = (next < 20); s_data = DW'(next);
            @(negedge clock);
            fire = s_valid && s_ready;
            advance();
            if (fire) next++;
        end
        s_valid = 1'b0;
        @(negedge clock);
        total++; if (next !== CAP) begin bad++; $display("FAIL fill_accepted got=%0d want=%0d", next, CAP); end
        total++; if (count !== CAP) begin bad++; $display("FAIL fill_count got=%0d want=%0d", count, CAP); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_s_ready got=%0d want=0", s_ready); end
        advance();
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && rx < CAP; cyc++) begin
            @(negedge clock);
            if (m_valid) begin
                total++; if (m_data !== DW'(rx)) begin bad++; $display("FAIL fill_order got=%0h want=%0h", m_data, rx); end
                rx++;
            end
            advance();
        end
        @(negedge clock);
        total++; if (rx !== CAP || count !== 0) begin
            bad++; $display("FAIL fill_drain got rx=%0d count=%0d want %0d/0", rx, count, CAP);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rx = 0;
        bit started = 0;
        logic fire;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && rx < 100; cyc++) begin
            s_valid = (sent < 100); s_data = $urandom;
            @(negedge clock);
            if (started && !m_valid) begin
                total++; bad++; $display("FAIL stream_bubble cyc=%0d got m_valid=0 want 1 rx=%0d", cyc, rx);
            end
            if (m_valid) begin
                total++;
                if (model_q.size() == 0) begin
                    bad++; $display("FAIL stream_spurious got=%0h want no word", m_data);
                end else if (m_data !== model_q[0]) begin
                    bad++; $display("FAIL stream_data got=%0h want=%0h", m_data, model_q[0]);
                end
                rx++; started = 1;
            end
            if (s_valid) begin
                total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stream_s_ready got=0 want=1 sent=%0d", sent); end
            end
            fire = s_valid && s_ready;
            advance();
            if (fire) sent++;
        end
        s_valid = 1'b0;
        @(negedge clock);
        total++; if (rx !== 100 || count !== 0) begin
            bad++; $display("FAIL stream_total got rx=%0d count=%0d want 100/0", rx, count);
        end
        advance();
    endtask

    task automatic test_random();
        int sent = 0;
        int rx = 0;
        bit stalled = 0;
        logic [DW-1:0] held = '0;
        logic fire;
        for (int cyc = 0; cyc < 12000 && rx < 1000; cyc++) begin
            s_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 1) == 1);
            @(negedge clock);
            total++; if (count !== model_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", count, model_q.size()); end
            if (model_q.size() >= CAP) begin
                total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rand_full got s_ready=1 want 0"); end
            end else if (model_q.size() < DEPTH) begin
                total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rand_room got s_ready=%0d want 1 held=%0d", s_ready, model_q.size()); end
            end
            if (m_valid) begin
                total++;
                if (model_q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious got=%0h want no word", m_data);
                end else if (m_data !== model_q[0]) begin
                    bad++; $display("FAIL rand_data got=%0h want=%0h", m_data, model_q[0]);
                end
            end
            if (stalled) begin
                total++; if (m_valid !== 1'b1 || m_data !== held) begin
                    bad++; $display("FAIL rand_hold got valid=%0d data=%0h want 1/%0h", m_valid, m_data, held);
                end
            end
            stalled = m_valid && !m_ready;
            held = m_data;
            if (m_valid && m_ready) rx++;
            fire = s_valid && s_ready;
            advance();
            if (fire) sent++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clock);
        total++; if (rx !== 1000 || sent !== 1000) begin
            bad++; $display("FAIL rand_total got rx=%0d sent=%0d want 1000/1000", rx, sent);
        end
        advance();
    endtask

    task automatic test_flush();
        int outs = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = DW'(100 + i);
            @(negedge clock);
            advance();
        end
        s_valid = 1'b0;
        repeat (3) begin @(negedge clock); advance(); end
        flush = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD;
        @(negedge clock);
        total++; if (count !== 10) begin bad++; $display("FAIL flush_pre_count got=%0d want=10", count); end
        total++; if (s_ready !== 1'b0 || ram_cen !== 1'b0 || ram_wen_a !== 1'b0) begin
            bad++; $display("FAIL flush_blocks got s_ready=%0d cen=%0d wen_a=%0d want 0/0/0", s_ready, ram_cen, ram_wen_a);
        end
        advance();
        flush = 1'b0; s_valid = 1'b0;
        @(negedge clock);
        total++; if (count !== 0 || m_valid !== 1'b0) begin
            bad++; $display("FAIL flush_cleared got count=%0d valid=%0d want 0/0", count, m_valid);
        end
        advance();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h77;
        @(negedge clock);
        advance();
        s_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            if (m_valid) begin
                total++; if (m_data !== 32'h77) begin bad++; $display("FAIL flush_after_data got=%0h want=77", m_data); end
                outs++;
            end
            advance();
        end
        @(negedge clock);
        total++; if (outs !== 1 || count !== 0) begin
            bad++; $display("FAIL flush_after_count got outs=%0d count=%0d want 1/0", outs, count);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        int outs = 0;
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'h1234;
        @(negedge clock); advance();
        s_data = 32'h5678;
        @(negedge clock); advance();
        s_valid = 1'b0;
        @(negedge clock); advance();
        #1;
        total++; if (m_valid !== 1'b1 || count !== 2) begin
            bad++; $display("FAIL midreset_pre got valid=%0d count=%0d want 1/2", m_valid, count);
        end
        reset = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0 || count !== 0 || ram_cen !== 1'b0) begin
            bad++; $display("FAIL midreset_async got valid=%0d count=%0d cen=%0d want 0/0/0", m_valid, count, ram_cen);
        end
        model_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h5;
        @(negedge clock); advance();
        s_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            if (m_valid) begin
                total++; if (m_data !== 32'h5) begin bad++; $display("FAIL midreset_data got=%0h want=5", m_data); end
                outs++;
            end
            advance();
        end
        total++; if (outs !== 1) begin bad++; $display("FAIL midreset_outs got=%0d want=1", outs); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        test_reset();
        test_single_word();
        test_fill();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
